// File: rtl/mbinit_sb_pkg.sv
// mbinit_sb_pkg
//   Shared definitions for the MBINIT sideband transmit path:
//   - 4-bit sideband message codes for the MBINIT and REVERSALMB exchanges
//   - arbiter FSM state encoding
//   - grant encodings (one-hot per requester, zero when nobody owns the port)
package mbinit_sb_pkg;

  // MBINIT message codes
  localparam logic [3:0] MSG_MBINIT_PARAM_CFG_REQ            = 4'b0001;
  localparam logic [3:0] MSG_MBINIT_PARAM_CFG_RESP           = 4'b0010;
  localparam logic [3:0] MSG_MBINIT_CAL_DONE_REQ             = 4'b0011;
  localparam logic [3:0] MSG_MBINIT_CAL_DONE_RESP            = 4'b0100;
  // REVERSALMB message codes
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_INIT_REQ      = 4'b0101;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_INIT_RESP     = 4'b0110;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_CLR_ERR_REQ   = 4'b0111;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_CLR_ERR_RESP  = 4'b1000;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_RESULT_REQ    = 4'b1001;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_RESULT_RESP   = 4'b1010;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_DONE_REQ      = 4'b1011;
  localparam logic [3:0] MSG_MBINIT_REVERSALMB_DONE_RESP     = 4'b1100;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_e;

  // Grant encodings
  localparam logic [1:0] GNT_NONE    = 2'b00;
  localparam logic [1:0] GNT_SELF    = 2'b01;
  localparam logic [1:0] GNT_PARTNER = 2'b10;

endpackage

// File: rtl/sb_busy_edge_det.sv
// sb_busy_edge_det
//   Falling-edge detector for the sideband transmitter busy flag.
//   One history flop plus an output gate; o_fall is combinational and is
//   high in the cycle where busy is low but was high on the previous edge.
// Ports:
//   clk    in  clock (rising edge)
//   rst    in  asynchronous active-high reset (history cleared to 0)
//   i_busy in  sideband busy
//   o_fall out busy falling edge (history=1, current=0)
module sb_busy_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  output logic o_fall
);

  logic busy_q;
  logic busy_d;

  always_comb begin
    busy_d = i_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_fall = busy_q & ~i_busy;

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// mbinit_sb_tx_arbiter
//   Arbitrates the single sideband transmitter between the ModuleSelf and
//   ModulePartner MBINIT requesters. A request is latched on grant, launched
//   with a one-cycle o_sb_valid once the transmitter is not busy, and is
//   complete when busy falls; the owner then gets a one-cycle done pulse.
//   Ties are broken round-robin (the requester not served last wins).
// Ports:
//   CLK, rst                       clock, asynchronous active-high reset
//   i_self_*    / i_partner_*      request valid, msg, data_valid, data
//   i_Busy_SideBand                sideband transmitter busy
//   o_sb_valid                     one-cycle launch strobe
//   o_sb_msg/_data_valid/_data     latched message of the granted requester
//   o_grant                        01 self, 10 partner, 00 none
//   o_self_done / o_partner_done   one-cycle completion pulses
//   o_timeout_err                  one-cycle timeout pulse
// Configuration:
//   MBINIT_SB_ARB_TIMEOUT_EN       when defined, WAIT_BUSY gives up after
//                                  TO_CYCLES cycles without a busy falling
//                                  edge; otherwise it waits indefinitely and
//                                  o_timeout_err is tied low.
module mbinit_sb_tx_arbiter
  import mbinit_sb_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        i_self_valid,
  input  logic [3:0]  i_self_msg,
  input  logic        i_self_data_valid,
  input  logic [15:0] i_self_data,
  input  logic        i_partner_valid,
  input  logic [3:0]  i_partner_msg,
  input  logic        i_partner_data_valid,
  input  logic [15:0] i_partner_data,
  input  logic        i_Busy_SideBand,
  output logic        o_sb_valid,
  output logic [3:0]  o_sb_msg,
  output logic        o_sb_data_valid,
  output logic [15:0] o_sb_data,
  output logic [1:0]  o_grant,
  output logic        o_self_done,
  output logic        o_partner_done,
  output logic        o_timeout_err
);

  if (TO_CYCLES < 1 || TO_CYCLES > 1023) begin : g_to_cycles_range
    $error("mbinit_sb_tx_arbiter: TO_CYCLES must be in 1..1023");
  end

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        sb_valid_q, sb_valid_d;
  logic [3:0]  msg_q, msg_d;
  logic        dv_q, dv_d;
  logic [15:0] data_q, data_d;
  logic        self_done_q, self_done_d;
  logic        partner_done_q, partner_done_d;
  // 1 = self was served last, so partner wins the next tie
  logic        last_self_q, last_self_d;

  logic        busy_fall;
  logic        pick_self;
  logic        granted_valid;
  logic        release_txn;

`ifdef MBINIT_SB_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TO_CYCLES - 1);
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       timeout_err_q, timeout_err_d;
`endif

  sb_busy_edge_det u_busy_edge (
    .clk    (CLK),
    .rst    (rst),
    .i_busy (i_Busy_SideBand),
    .o_fall (busy_fall)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    sb_valid_d     = 1'b0;
    msg_d          = msg_q;
    dv_d           = dv_q;
    data_d         = data_q;
    self_done_d    = 1'b0;
    partner_done_d = 1'b0;
    last_self_d    = last_self_q;
    pick_self      = 1'b0;
    granted_valid  = 1'b0;
    release_txn    = 1'b0;
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_self_valid || i_partner_valid) begin
          pick_self   = i_self_valid && (!i_partner_valid || !last_self_q);
          state_d     = ST_ISSUE;
          last_self_d = pick_self;
          if (pick_self) begin
            grant_d = GNT_SELF;
            msg_d   = i_self_msg;
            dv_d    = i_self_data_valid;
            data_d  = i_self_data;
          end else begin
            grant_d = GNT_PARTNER;
            msg_d   = i_partner_msg;
            dv_d    = i_partner_data_valid;
            data_d  = i_partner_data;
          end
        end
      end

      ST_ISSUE: begin
        granted_valid = (grant_q == GNT_SELF) ? i_self_valid : i_partner_valid;
        // A withdrawn request is dropped silently; it never reached the wire.
        if (!granted_valid) begin
          release_txn = 1'b1;
        end else if (!i_Busy_SideBand) begin
          sb_valid_d = 1'b1;
          state_d    = ST_WAIT_BUSY;
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end

      ST_WAIT_BUSY: begin
        // Requester valids are not looked at here: once launched, it completes.
        if (busy_fall) begin
          state_d        = ST_DONE;
          self_done_d    = (grant_q == GNT_SELF);
          partner_done_d = (grant_q == GNT_PARTNER);
        end
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          release_txn   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
`endif
      end

      default: begin
        release_txn = 1'b1;
      end
    endcase

    if (release_txn) begin
      state_d = ST_IDLE;
      grant_d = GNT_NONE;
      msg_d   = '0;
      dv_d    = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= GNT_NONE;
      sb_valid_q     <= 1'b0;
      msg_q          <= '0;
      dv_q           <= 1'b0;
      data_q         <= '0;
      self_done_q    <= 1'b0;
      partner_done_q <= 1'b0;
      last_self_q    <= 1'b1;
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
      to_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      sb_valid_q     <= sb_valid_d;
      msg_q          <= msg_d;
      dv_q           <= dv_d;
      data_q         <= data_d;
      self_done_q    <= self_done_d;
      partner_done_q <= partner_done_d;
      last_self_q    <= last_self_d;
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      timeout_err_q  <= timeout_err_d;
`endif
    end
  end

  assign o_sb_valid      = sb_valid_q;
  assign o_sb_msg        = msg_q;
  assign o_sb_data_valid = dv_q;
  assign o_sb_data       = data_q;
  assign o_grant         = grant_q;
  assign o_self_done     = self_done_q;
  assign o_partner_done  = partner_done_q;
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
  assign o_timeout_err   = timeout_err_q;
`else
  assign o_timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
module tb_mbinit_sb_tx_arbiter;
  import mbinit_sb_pkg::*;

  logic        CLK;
  logic        rst;
  logic        i_self_valid;
  logic [3:0]  i_self_msg;
  logic        i_self_data_valid;
  logic [15:0] i_self_data;
  logic        i_partner_valid;
  logic [3:0]  i_partner_msg;
  logic        i_partner_data_valid;
  logic [15:0] i_partner_data;
  logic        i_Busy_SideBand;
  logic        o_sb_valid;
  logic [3:0]  o_sb_msg;
  logic        o_sb_data_valid;
  logic [15:0] o_sb_data;
  logic [1:0]  o_grant;
  logic        o_self_done;
  logic        o_partner_done;
  logic        o_timeout_err;

  int checks = 0;
  int errors = 0;
  // Reference model: which requester was served most recently (1 = self).
  bit last_self;

  mbinit_sb_tx_arbiter #(.TO_CYCLES(16)) dut (
    .CLK                  (CLK),
    .rst                  (rst),
    .i_self_valid         (i_self_valid),
    .i_self_msg           (i_self_msg),
    .i_self_data_valid    (i_self_data_valid),
    .i_self_data          (i_self_data),
    .i_partner_valid      (i_partner_valid),
    .i_partner_msg        (i_partner_msg),
    .i_partner_data_valid (i_partner_data_valid),
    .i_partner_data       (i_partner_data),
    .i_Busy_SideBand      (i_Busy_SideBand),
    .o_sb_valid           (o_sb_valid),
    .o_sb_msg             (o_sb_msg),
    .o_sb_data_valid      (o_sb_data_valid),
    .o_sb_data            (o_sb_data),
    .o_grant              (o_grant),
    .o_self_done          (o_self_done),
    .o_partner_done       (o_partner_done),
    .o_timeout_err        (o_timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {5'd0, o_grant, o_sb_valid, o_sb_msg, o_sb_data_valid, o_sb_data,
              o_self_done, o_partner_done, o_timeout_err}, 32'd0);
  endtask

  task automatic set_self(input logic v, input logic [3:0] m, input logic dv, input logic [15:0] d);
    i_self_valid = v; i_self_msg = m; i_self_data_valid = dv; i_self_data = d;
  endtask

  task automatic set_partner(input logic v, input logic [3:0] m, input logic dv, input logic [15:0] d);
    i_partner_valid = v; i_partner_msg = m; i_partner_data_valid = dv; i_partner_data = d;
  endtask

  // Called in an IDLE cycle with at least one request driven. Busy is held
  // high for ib cycles in ISSUE, then high for wb cycles after launch.
  task automatic serve(input string tag, input int ib, input int wb);
    bit          pick_self;
    logic [1:0]  egnt;
    logic [20:0] efields;
    if (i_self_valid && i_partner_valid) pick_self = !last_self;
    else pick_self = i_self_valid;
    egnt    = pick_self ? GNT_SELF : GNT_PARTNER;
    efields = pick_self ? {i_self_msg, i_self_data_valid, i_self_data}
                        : {i_partner_msg, i_partner_data_valid, i_partner_data};
    last_self = pick_self;
    i_Busy_SideBand = (ib > 0);
    tick();
    chk({tag, "_grant"}, {o_grant, o_sb_valid}, {egnt, 1'b0});
    chk({tag, "_fields"}, {o_sb_msg, o_sb_data_valid, o_sb_data}, efields);
    for (int k = 0; k < ib; k++) begin
      tick();
      chk({tag, "_hold"}, {o_grant, o_sb_valid}, {egnt, 1'b0});
    end
    i_Busy_SideBand = 1'b0;
    tick();
    chk({tag, "_launch"}, {o_sb_valid, o_sb_msg, o_sb_data_valid, o_sb_data}, {1'b1, efields});
    i_Busy_SideBand = 1'b1;
    for (int k = 0; k < wb; k++) begin
      tick();
      chk({tag, "_wait"}, {o_grant, o_sb_valid, o_self_done, o_partner_done, o_timeout_err},
          {egnt, 4'b0000});
    end
    i_Busy_SideBand = 1'b0;
    tick();
    chk({tag, "_done"}, {o_grant, o_self_done, o_partner_done},
        {egnt, pick_self, !pick_self});
    if (pick_self) i_self_valid = 1'b0;
    else i_partner_valid = 1'b0;
    tick();
    chk_idle({tag, "_idle"});
    $display("txn %s: %s served msg=%h dv=%0d data=%h", tag, pick_self ? "self" : "partner",
             efields[20:17], efields[16], efields[15:0]);
  endtask

  initial begin
    rst = 1'b1;
    set_self(1'b0, 4'd0, 1'b0, 16'd0);
    set_partner(1'b0, 4'd0, 1'b0, 16'd0);
    i_Busy_SideBand = 1'b0;
    last_self = 1'b1;
    repeat (3) tick();
    chk_idle("reset_state");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Self only, busy high 5 cycles after launch
    set_self(1'b1, MSG_MBINIT_PARAM_CFG_REQ, 1'b0, 16'h0000);
    serve("self_only", 0, 5);

    // Busy held in ISSUE for 10 cycles
    set_self(1'b1, MSG_MBINIT_CAL_DONE_REQ, 1'b1, 16'h3C3C);
    serve("busy_issue", 10, 3);

    // Self withdraws while stuck in ISSUE
    set_self(1'b1, MSG_MBINIT_REVERSALMB_INIT_REQ, 1'b0, 16'h0000);
    i_Busy_SideBand = 1'b1;
    last_self = 1'b1;
    tick();
    chk("abort_grant", {o_grant, o_sb_valid}, {GNT_SELF, 1'b0});
    i_self_valid = 1'b0;
    tick();
    chk_idle("abort_idle");
    tick();
    chk_idle("abort_quiet");
    i_Busy_SideBand = 1'b0;
    $display("txn abort: self withdrew before launch");

    // Busy stuck high after launch
    set_self(1'b1, MSG_MBINIT_REVERSALMB_RESULT_REQ, 1'b1, 16'hBEEF);
    last_self = 1'b1;
    tick();
    chk("stuck_grant", {30'd0, o_grant}, {30'd0, GNT_SELF});
    tick();
    chk("stuck_launch", {31'd0, o_sb_valid}, 32'd1);
    i_Busy_SideBand = 1'b1;
`ifdef MBINIT_SB_ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("stuck_wait", {o_timeout_err, o_self_done, o_grant}, {2'b00, GNT_SELF});
    end
    tick();
    chk("stuck_timeout", {o_timeout_err, o_self_done, o_grant, o_sb_msg}, {2'b10, GNT_NONE, 4'd0});
    i_self_valid = 1'b0;
    i_Busy_SideBand = 1'b0;
    tick();
    chk_idle("stuck_after");
    $display("txn stuck: timeout pulse seen");
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("stuck_wait", {o_timeout_err, o_self_done, o_grant}, {2'b00, GNT_SELF});
    end
    i_Busy_SideBand = 1'b0;
    tick();
    chk("stuck_release", {o_timeout_err, o_self_done, o_grant}, {2'b01, GNT_SELF});
    i_self_valid = 1'b0;
    tick();
    chk_idle("stuck_after");
    $display("txn stuck: waited 40 cycles then completed");
`endif

    // Reset mid-transaction while partner owns the port
    set_partner(1'b1, MSG_MBINIT_PARAM_CFG_RESP, 1'b1, 16'h1357);
    tick();
    chk("rst_grant", {30'd0, o_grant}, {30'd0, GNT_PARTNER});
    tick();
    i_Busy_SideBand = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk_idle("rst_async");
    tick();
    chk_idle("rst_held");
    rst = 1'b0;
    set_partner(1'b0, 4'd0, 1'b0, 16'd0);
    i_Busy_SideBand = 1'b0;
    last_self = 1'b1;
    tick();
    chk_idle("rst_release");
    $display("txn reset: outputs cleared mid-transaction");

    // Tie after reset: partner first, then partner re-requests -> self wins
    set_self(1'b1, 4'b0101, 1'b1, 16'hA5A5);
    set_partner(1'b1, 4'b0010, 1'b0, 16'h0000);
    serve("tie_first", 0, 2);
    set_partner(1'b1, MSG_MBINIT_REVERSALMB_DONE_RESP, 1'b1, 16'h1234);
    serve("tie_second", 0, 2);
    serve("tie_leftover", 1, 1);

    // Randomized traffic: pending requests persist until served
    for (int it = 0; it < 30; it++) begin
      if (!i_self_valid && $urandom_range(0, 1) == 1)
        set_self(1'b1, 4'($urandom), 1'($urandom), 16'($urandom));
      if (!i_partner_valid && $urandom_range(0, 1) == 1)
        set_partner(1'b1, 4'($urandom), 1'($urandom), 16'($urandom));
      if (!i_self_valid && !i_partner_valid)
        set_self(1'b1, 4'($urandom), 1'($urandom), 16'($urandom));
      serve("rand", $urandom_range(0, 3), $urandom_range(1, 4));
    end
    for (int k = 0; k < 2; k++) begin
      if (i_self_valid || i_partner_valid) serve("drain", 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbinit_sb_tx_arbiter.md
MBINIT_SB_TX_ARBITER -- requirements
Module: mbinit_sb_tx_arbiter

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 1023, meaning the number of cycles to wait for a busy falling edge before timeout (range 1..1023, 10-bit counter).
REQ-002 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_self_valid  in  1  ModuleSelf request; held until o_self_done.
REQ-005 SHALL have port i_self_msg  in  4  ModuleSelf sideband message code.
REQ-006 SHALL have port i_self_data_valid  in  1  ModuleSelf data field present.
REQ-007 SHALL have port i_self_data  in  16  ModuleSelf data field.
REQ-008 SHALL have ports i_partner_valid / i_partner_msg / i_partner_data_valid / i_partner_data  in  1/4/1/16  ModulePartner equivalents.
REQ-009 SHALL have port i_Busy_SideBand  in  1  sideband transmitter busy.
REQ-010 SHALL have port o_sb_valid  out  1  one-cycle message launch strobe.
REQ-011 SHALL have ports o_sb_msg / o_sb_data_valid / o_sb_data  out  4/1/16  latched message of the granted requester.
REQ-012 SHALL have port o_grant  out  2  01 = self, 10 = partner, 00 = none.
REQ-013 SHALL have ports o_self_done / o_partner_done  out  1  one-cycle completion pulses.
REQ-014 SHALL have port o_timeout_err  out  1  one-cycle timeout pulse (configuration dependent).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, DONE; all outputs registered.
REQ-016 In IDLE with any valid high, SHALL move to ISSUE next cycle, latch the winner's msg/data, and set o_grant.
REQ-017 On simultaneous requests, SHALL grant the requester not served last (round-robin); after reset, partner wins the first tie.
REQ-018 In ISSUE with i_Busy_SideBand=0, SHALL pulse o_sb_valid for exactly one cycle (next cycle) and move to WAIT_BUSY; while busy=1 it SHALL stay in ISSUE.
REQ-019 In ISSUE, if the granted valid drops before launch, SHALL return to IDLE, clear o_grant, and issue no done pulse.
REQ-020 In WAIT_BUSY, SHALL detect a busy falling edge (registered busy=1, current busy=0), move to DONE, and pulse the granted requester's done for one cycle.
REQ-021 A requester valid drop after launch SHALL be ignored; the transaction completes.
REQ-022 DONE SHALL go to IDLE unconditionally; requester valids SHALL be ignored in the DONE cycle, and o_grant SHALL clear on entry to IDLE.
REQ-023 o_sb_msg/o_sb_data/o_sb_data_valid SHALL hold the latched values from grant until return to IDLE, then clear to 0.
REQ-024 Minimum latency SHALL be: valid sampled at cycle 0 -> o_grant at 1 -> o_sb_valid at 2 (busy low).
REQ-025 The ungranted requester SHALL never see a done pulse and SHALL be served in the next IDLE arbitration.

Reset
REQ-026 rst SHALL force IDLE, all outputs to 0, the round-robin pointer to "self served last", the busy history register to 0, and the timeout counter to 0, including mid-transaction.

Configuration
REQ-027 With MBINIT_SB_ARB_TIMEOUT_EN defined: in WAIT_BUSY, a counter SHALL count from 0; on reaching TO_CYCLES without a falling edge, SHALL pulse o_timeout_err, skip done, and return to IDLE.
REQ-028 Without MBINIT_SB_ARB_TIMEOUT_EN: no counter SHALL exist, o_timeout_err SHALL be tied to 0, and WAIT_BUSY SHALL wait indefinitely.

Structure
REQ-029 Package mbinit_sb_pkg SHALL hold the 4-bit REVERSALMB/MBINIT message code constants, the arbiter state encoding, and the grant encodings (GNT_NONE/GNT_SELF/GNT_PARTNER).
REQ-030 Busy falling-edge detection SHALL be a sub-module sb_busy_edge_det (1 flop plus output gate), reusable by other MBINIT blocks.

Verification
REQ-031 Self only: i_self_msg=4'b0001, busy low -> o_grant=01 at cycle 1; o_sb_valid=1 with o_sb_msg=0001 at cycle 2; busy 1 for 5 cycles then 0 -> o_self_done one cycle later.
REQ-032 Tie: both valid in the same cycle after reset -> partner (msg 4'b0010) first; self (msg 4'b0101, data 16'hA5A5) second with o_sb_data_valid=1; then tie again -> self wins.
REQ-033 Busy held high in ISSUE for 10 cycles -> no o_sb_valid until busy drops; then exactly one launch pulse.
REQ-034 Self valid drops in ISSUE -> back to IDLE, o_grant=00, no done pulse, no launch.
REQ-035 With timeout enabled and TO_CYCLES=16, busy stuck at 1 -> o_timeout_err pulse after 16 WAIT_BUSY cycles, no done, then IDLE; without the macro, stays in WAIT_BUSY.
REQ-036 rst asserted in WAIT_BUSY -> all outputs 0 immediately; after release, a new request completes normally.
